alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Two-requester arbiter and sequencer for the team's 32-bit ALU block (ports a, b, f, y, zero), which it instantiates internally.
- Accepts operations over valid/ready, grants requesters round-robin, and registers the operands.
- Runs the ALU on the registered operands, then returns the registered result to the owning requester over a second valid/ready handshake.
- Sits between the decode/issue logic and the single shared ALU, so two clients (e.g. a main pipe and a helper unit) can share one adder/logic array.

Parameters:
- CNT_W, 16, width of the completed-operation counter ops_done.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  requester 0 operand a.
- req0_b  in  32  requester 0 operand b.
- req0_f  in  4  requester 0 ALU function code, passed to the ALU unmodified.
- req1_valid, req1_ready, req1_a, req1_b, req1_f: same as requester 0, for requester 1.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 consumes the result.
- rsp1_valid  out  1  result available for requester 1.
- rsp1_ready  in  1  requester 1 consumes the result.
- rsp_y  out  32  registered ALU result, shared by both responders.
- rsp_zero  out  1  registered ALU zero flag.
- busy  out  1  high in any state other than IDLE.
- ops_done  out  CNT_W  count of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, last_grant=1 (requester 0 has priority first), op_a/op_b=0, op_f=0, owner=0, rsp_y=0, rsp_zero=0, rsp*_valid=0, req*_ready=0, busy=0, ops_done=0.
- Reset mid-operation: asserting rst_n low in any state clears everything immediately. The in-flight operation is dropped with no response.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - Both req*_valid high: grant the requester != last_grant.
  - Only one valid: grant that requester.
  - None valid: stay in IDLE.
- IDLE, grant:
  - reqN_ready is combinational and high only in IDLE for the granted requester. At most one ready is high per cycle.
  - On the edge where reqN_valid && reqN_ready: latch a, b, f into op_a, op_b, op_f; set owner=N and last_grant=N; go to EXEC.
- EXEC: the ALU is driven from op_a, op_b, op_f. At the edge, capture y into rsp_y and zero into rsp_zero, then go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid is 0.
  - On rsp<owner>_ready high at an edge: ops_done+=1, go to IDLE.
  - Otherwise hold; rsp_y and rsp_zero stay stable.
- Latency: accept at edge T; rsp valid is high from edge T+2. Minimum issue interval is 3 cycles; no overlap.
- Requester rule: a, b, f must stay stable while valid is high and ready is low. The arbiter never samples operands outside the accept edge.
- A requester may deassert valid before being granted; no operation is recorded.
- ALU semantics are the shared ALU's:
  - f[3] inverts b and adds carry-in.
  - f[2:0]: 000 = AND, 001 = OR, 010 = add/sub, 011 = set-less-than from sum bit 31.
  - 1xx yields 0 with zero=1.
  - The arbiter forwards these results unchanged and does not flag illegal codes.
- ops_done wrap: from all-ones it goes to 0.
- A new request arriving during EXEC or RESP waits; its ready stays low.

Test Plan:
- Single op, add: reset; req0 a=5, b=3, f=0010 → req0_ready at edge T; rsp0_valid from T+2 with rsp_y=8, rsp_zero=0; rsp1_valid=0; ops_done=1 after rsp0_ready.
- Subtract and zero flag:
  - req1 a=7, b=7, f=1010 → rsp_y=0, rsp_zero=1.
  - a=5, b=3, f=1010 → rsp_y=2.
  - a=3, b=5, f=1011 → rsp_y=1.
- Round-robin: both valid continuously with rsp ready tied high → grants go 0,1,0,1. Accept edges are 3 cycles apart. Responses go to the matching rsp*_valid, and ops_done increments by 1 per response.
- Backpressure: hold rsp0_ready=0 for 10 cycles in RESP → rsp0_valid, rsp_y, rsp_zero stable; req1_ready stays 0 although req1_valid=1. Release ready → IDLE, then req1 is granted.
- Reset mid-op: assert rst_n low during EXEC → all outputs return to reset values immediately, no response. After release, the first contention grants requester 0.
- Counter wrap with CNT_W=2: complete 5 operations → ops_done reads 1,2,3,0,1. A function code of 0100 with a=0xFFFFFFFF → rsp_y=0, rsp_zero=1.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between two ALU clients and the shared-ALU arbiter.
interface alu_share_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_f;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_f;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_y;
    logic        rsp_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_f,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_f,
        input  req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_y, rsp_zero,
        output rsp0_ready, rsp1_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_f,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_f,
        output req1_ready,
        output rsp0_valid, rsp1_valid, rsp_y, rsp_zero,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters.
// Latency: accept at edge T, response valid sampled from edge T+2; one op in flight.
// Backpressure: response held stable until the owner's ready; new requests wait (ready low).
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  f,
    output logic [31:0] y,
    output logic        zero
);
    logic [31:0] bb;
    logic [31:0] sum;

    assign bb  = f[3] ? ~b : b;
    assign sum = a + bb + {31'd0, f[3]};

    always_comb begin
        y = 32'd0;
        case (f[2:0])
            3'b000:  y = a & bb;
            3'b001:  y = a | bb;
            3'b010:  y = sum;
            3'b011:  y = {31'd0, sum[31]};
            default: y = 32'd0;
        endcase
    end

    assign zero = (y == 32'd0);
endmodule

module alu_share_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_arb_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        last_grant;
    logic        owner;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_f;
    logic [31:0] y_q;
    logic        zero_q;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        rsp_take;

    // On contention the requester that did not win last time goes first.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

    assign bus.req0_ready = (state == IDLE) && grant0;
    assign bus.req1_ready = (state == IDLE) && grant1;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign bus.rsp0_valid = (state == RESP) && !owner;
    assign bus.rsp1_valid = (state == RESP) &&  owner;
    assign rsp_take       = owner ? bus.rsp1_ready : bus.rsp0_ready;

    assign bus.rsp_y    = y_q;
    assign bus.rsp_zero = zero_q;
    assign busy         = (state != IDLE);

    alu u_alu (
        .a    (op_a),
        .b    (op_b),
        .f    (op_f),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            op_f       <= 4'd0;
            y_q        <= 32'd0;
            zero_q     <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant1 ? bus.req1_a : bus.req0_a;
                        op_b       <= grant1 ? bus.req1_b : bus.req0_b;
                        op_f       <= grant1 ? bus.req1_f : bus.req0_f;
                        owner      <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    y_q    <= alu_y;
                    zero_q <= alu_zero;
                    state  <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: vector table plus round-robin, backpressure and reset sequences.
module tb_alu_share_arb;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [CNT_W-1:0] ops_done;

    always #5 clk = ~clk;

    alu_share_arb_if bus();

    alu_share_arb #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .ops_done (ops_done)
    );

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        logic [31:0] y;
        logic        z;
    } vec_t;

    vec_t vt[10];
    int errors = 0;
    int checks = 0;
    int exp_ops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
        return 32'(exp_ops % (1 << CNT_W));
    endfunction

    function automatic logic rdy(input logic s);
        return s ? bus.req1_ready : bus.req0_ready;
    endfunction

    function automatic logic vld(input logic s);
        return s ? bus.rsp1_valid : bus.rsp0_valid;
    endfunction

    task automatic set_req(input logic s, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f);
        if (s) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_f = f;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_f = f;
        end
    endtask

    task automatic set_rsp(input logic s, input logic v);
        if (s) bus.rsp1_ready = v;
        else   bus.rsp0_ready = v;
    endtask

    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [31:0] ey, input logic ez);
        @(negedge clk);
        set_req(s, 1'b1, a, b, f);
        #1;
        chk("acc_ready", rdy(s), 1);
        chk("acc_other_ready", rdy(!s), 0);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        // Scramble operands after the accept edge: only the accepted values may matter.
        set_req(s, 1'b0, ~a, ~b, ~f);
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_rsp0", bus.rsp0_valid, 0);
        chk("exec_rsp1", bus.rsp1_valid, 0);
        @(negedge clk);
        #1;
        chk("resp_valid", vld(s), 1);
        chk("resp_other", vld(!s), 0);
        chk("rsp_y", bus.rsp_y, ey);
        chk("rsp_zero", bus.rsp_zero, ez);
        set_rsp(s, 1'b1);
        @(negedge clk);
        set_rsp(s, 1'b0);
        exp_ops++;
        #1;
        chk("ops_done", ops_done, exp_cnt());
        chk("done_busy", busy, 0);
    endtask

    initial begin
        int ngrants;
        int lastc;
        logic g;
        logic own;

        vt[0] = '{1'b0, 32'd5,         32'd3,         4'b0010, 32'd8,         1'b0};
        vt[1] = '{1'b1, 32'd7,         32'd7,         4'b1010, 32'd0,         1'b1};
        vt[2] = '{1'b0, 32'd5,         32'd3,         4'b1010, 32'd2,         1'b0};
        vt[3] = '{1'b1, 32'd3,         32'd5,         4'b1011, 32'd1,         1'b0};
        vt[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         4'b0100, 32'd0,         1'b1};
        vt[5] = '{1'b1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0000, 32'h00F0_000F, 1'b0};
        vt[6] = '{1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0001, 32'hFFF0_0FFF, 1'b0};
        vt[7] = '{1'b1, 32'd5,         32'd3,         4'b1000, 32'd4,         1'b0};
        vt[8] = '{1'b0, 32'h8000_0000, 32'd1,         4'b1011, 32'd0,         1'b1};
        vt[9] = '{1'b1, 32'h7FFF_FFFF, 32'd1,         4'b0010, 32'h8000_0000, 1'b0};

        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ops", ops_done, 0);
        chk("rst_rsp_y", bus.rsp_y, 0);
        chk("rst_rsp_zero", bus.rsp_zero, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        rst_n = 1'b1;

        // Counter runs 1,2,3,0,1,... across the table with CNT_W=2.
        for (int i = 0; i < 10; i++)
            do_op(vt[i].sel, vt[i].a, vt[i].b, vt[i].f, vt[i].y, vt[i].z);

        // Reset while an op is in EXEC: dropped with no response.
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 4'b0010);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        chk("mid_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        exp_ops = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ops", ops_done, 0);
        chk("mid_rst_rsp_y", bus.rsp_y, 0);
        chk("mid_rst_rsp_zero", bus.rsp_zero, 0);
        chk("mid_rst_rsp0", bus.rsp0_valid, 0);
        chk("mid_rst_rsp1", bus.rsp1_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("no_rsp_after_rst", bus.rsp0_valid | bus.rsp1_valid, 0);

        // Round-robin under continuous contention, responses consumed immediately.
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 4'b0010);
        set_req(1'b1, 1'b1, 32'd10, 32'd4, 4'b1010);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        ngrants = 0;
        lastc = 0;
        own = 1'b0;
        for (int c = 0; c < 40 && ngrants < 4; c++) begin
            #1;
            chk("rr_ops", ops_done, exp_cnt());
            if (bus.req0_ready || bus.req1_ready) begin
                g = bus.req1_ready;
                chk("rr_order", g, 32'(ngrants % 2));
                chk("rr_single_ready", bus.req0_ready & bus.req1_ready, 0);
                if (ngrants > 0) chk("rr_interval", 32'(c - lastc), 3);
                lastc = c;
                own = g;
                ngrants++;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                chk("rr_route", bus.rsp1_valid, own);
                chk("rr_y", bus.rsp_y, own ? 32'd6 : 32'd3);
                exp_ops++;
            end
            @(negedge clk);
        end
        chk("rr_grants", ngrants, 4);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        exp_ops++;
        #1;
        chk("rr_ops_final", ops_done, exp_cnt());
        chk("rr_idle", busy, 0);

        // Backpressure: hold the response for 10 cycles while req1 waits.
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'd20, 32'd22, 4'b0010);
        #1;
        chk("bp_ready0", bus.req0_ready, 1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b1, 32'd9, 32'd4, 4'b1010);
        #1;
        chk("bp_exec_ready1", bus.req1_ready, 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_rsp0_valid", bus.rsp0_valid, 1);
            chk("bp_rsp1_valid", bus.rsp1_valid, 0);
            chk("bp_rsp_y", bus.rsp_y, 32'd42);
            chk("bp_rsp_zero", bus.rsp_zero, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            @(negedge clk);
        end
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        exp_ops++;
        #1;
        chk("bp_ops", ops_done, exp_cnt());
        chk("bp_rsp0_done", bus.rsp0_valid, 0);
        chk("bp_grant1", bus.req1_ready, 1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        chk("bp_rsp1_valid_after", bus.rsp1_valid, 1);
        chk("bp_rsp1_y", bus.rsp_y, 32'd5);
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        bus.rsp1_ready = 1'b0;
        exp_ops++;
        #1;
        chk("bp_ops_final", ops_done, exp_cnt());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
